// File: rtl/stopwatch_controller_pkg.sv
// Shared types and digit limits for the MM:SS stopwatch controller.
package stopwatch_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_RESTART = 2'd2,
    ST_PAUSED  = 2'd3
  } sw_state_t;

  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_TENS_MAX = 5;
  localparam int BCD_MAX      = 9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One wrapping digit of the MM:SS chain; carry is combinational so a whole
// chain ripples within one cycle, while the digit value itself is registered.
module bcd_digit_counter #(
  parameter int MAX = 9,
  parameter int W   = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W-1:0] value_q, value_d;

  assign carry = inc && (value_q == W'(MAX));
  assign value = value_q;

  // Next digit: clear wins, otherwise step and wrap at MAX.
  always_comb begin
    value_d = value_q;
    if (clr)
      value_d = '0;
    else if (inc)
      value_d = (value_q == W'(MAX)) ? '0 : value_q + 1'b1;
  end

  // Digit register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) value_q <= '0;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch FSM: counts timer markers as BCD MM:SS and restarts the
// saturating one-second timer after each marker it consumes.
module stopwatch_controller
  import stopwatch_controller_pkg::*;
#(
  parameter bit WRAP_ENABLE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       startStop,
  input  logic       clear,
  input  logic       secondMarker,
  output logic       timerReset,
  output logic       timerEnable,
  output logic [3:0] secOnes,
  output logic [2:0] secTens,
  output logic [3:0] minOnes,
  output logic [2:0] minTens,
  output logic       running,
  output logic       tick,
  output logic       rollover
);

  sw_state_t state_q, state_d;
  logic stop_pend_q, stop_pend_d;
  logic timer_rst_q, timer_rst_d;
  logic timer_en_q, timer_en_d;
  logic running_q, running_d;
  logic tick_q, tick_d;
  logic rollover_q, rollover_d;

  logic count_ev, at_max, saturate, inc_so;
  logic c_so, c_st, c_mo, c_mt;

  // A marker only counts while RUNNING; in RESTART it is the stale high
  // level of the saturated timer and must be ignored.
  assign count_ev = (state_q == ST_RUNNING) && secondMarker && !clear;
  assign at_max   = (secOnes == 4'(BCD_MAX)) && (secTens == 3'(SEC_TENS_MAX)) &&
                    (minOnes == 4'(BCD_MAX)) && (minTens == 3'(MIN_TENS_MAX));
  assign saturate = count_ev && at_max && !WRAP_ENABLE;
  assign inc_so   = count_ev && !saturate;

  bcd_digit_counter #(.MAX(BCD_MAX), .W(4)) u_sec_ones (
    .clock(clock), .reset(reset), .inc(inc_so), .clr(clear), .value(secOnes), .carry(c_so));
  bcd_digit_counter #(.MAX(SEC_TENS_MAX), .W(3)) u_sec_tens (
    .clock(clock), .reset(reset), .inc(c_so), .clr(clear), .value(secTens), .carry(c_st));
  bcd_digit_counter #(.MAX(BCD_MAX), .W(4)) u_min_ones (
    .clock(clock), .reset(reset), .inc(c_st), .clr(clear), .value(minOnes), .carry(c_mo));
  bcd_digit_counter #(.MAX(MIN_TENS_MAX), .W(3)) u_min_tens (
    .clock(clock), .reset(reset), .inc(c_mo), .clr(clear), .value(minTens), .carry(c_mt));

  // Next state plus outputs decoded from the next state so they land registered.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    if (clear) begin
      state_d     = ST_IDLE;
      stop_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:    if (startStop) state_d = ST_RUNNING;
        ST_RUNNING: begin
          if (secondMarker) begin
            // A stop arriving with the marker still lets RESTART run first.
            state_d     = saturate ? ST_PAUSED : ST_RESTART;
            stop_pend_d = startStop && !saturate;
          end else if (startStop) begin
            state_d = ST_PAUSED;
          end
        end
        ST_RESTART: begin
          state_d     = (stop_pend_q || startStop) ? ST_PAUSED : ST_RUNNING;
          stop_pend_d = 1'b0;
        end
        ST_PAUSED:  if (startStop) state_d = ST_RUNNING;
        default:    state_d = ST_IDLE;
      endcase
    end
    timer_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESTART);
    timer_en_d  = (state_d == ST_RUNNING);
    running_d   = (state_d == ST_RUNNING) || (state_d == ST_RESTART);
    tick_d      = inc_so;
    rollover_d  = c_mt;
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      timer_rst_q <= 1'b1;
      timer_en_q  <= 1'b0;
      running_q   <= 1'b0;
      tick_q      <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      timer_rst_q <= timer_rst_d;
      timer_en_q  <= timer_en_d;
      running_q   <= running_d;
      tick_q      <= tick_d;
      rollover_q  <= rollover_d;
    end
  end

  assign timerReset  = timer_rst_q;
  assign timerEnable = timer_en_q;
  assign running     = running_q;
  assign tick        = tick_q;
  assign rollover    = rollover_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench: a wrapping and a saturating stopwatch driven in lockstep, each with
// its own saturating one-second timer model.
module tb_stopwatch_controller;

  logic clock = 1'b0, reset = 1'b1;
  logic startStop = 1'b0, clear = 1'b0, tbl_mk = 1'b0;
  bit   use_tbl = 1'b1;
  int   term = 10;
  int   tcnt_w = 0, tcnt_n = 0;
  logic mk_w, mk_n;

  logic tr_w, te_w, run_w, tk_w, ro_w, tr_n, te_n, run_n, tk_n, ro_n;
  logic [3:0] so_w, mo_w, so_n, mo_n;
  logic [2:0] st_w, mt_w, st_n, mt_n;

  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic [2:0]  in;   // {startStop, clear, secondMarker}
    logic [4:0]  fl;   // {running, timerReset, timerEnable, tick, rollover}
    logic [15:0] dg;   // MM:SS as four hex nibbles
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t e;

  always #5 clock = ~clock;

  assign mk_w = use_tbl ? tbl_mk : (tcnt_w == term);
  assign mk_n = use_tbl ? tbl_mk : (tcnt_n == term);

  always @(posedge clock) begin
    if (tr_w) tcnt_w <= 0; else if (te_w && tcnt_w < term) tcnt_w <= tcnt_w + 1;
    if (tr_n) tcnt_n <= 0; else if (te_n && tcnt_n < term) tcnt_n <= tcnt_n + 1;
  end

  stopwatch_controller #(.WRAP_ENABLE(1'b1)) dut_w (
    .clock(clock), .reset(reset), .startStop(startStop), .clear(clear),
    .secondMarker(mk_w), .timerReset(tr_w), .timerEnable(te_w),
    .secOnes(so_w), .secTens(st_w), .minOnes(mo_w), .minTens(mt_w),
    .running(run_w), .tick(tk_w), .rollover(ro_w));

  stopwatch_controller #(.WRAP_ENABLE(1'b0)) dut_n (
    .clock(clock), .reset(reset), .startStop(startStop), .clear(clear),
    .secondMarker(mk_n), .timerReset(tr_n), .timerEnable(te_n),
    .secOnes(so_n), .secTens(st_n), .minOnes(mo_n), .minTens(mt_n),
    .running(run_n), .tick(tk_n), .rollover(ro_n));

  function automatic logic [15:0] dig_w();
    return {1'b0, mt_w, mo_w, 1'b0, st_w, so_w};
  endfunction
  function automatic logic [15:0] dig_n();
    return {1'b0, mt_n, mo_n, 1'b0, st_n, so_n};
  endfunction
  function automatic logic [4:0] fl_w();
    return {run_w, tr_w, te_w, tk_w, ro_w};
  endfunction
  function automatic logic [4:0] fl_n();
    return {run_n, tr_n, te_n, tk_n, ro_n};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic v(input logic [2:0] in, input logic [4:0] fl, input logic [15:0] dg);
    vec_t t;
    t.in = in; t.fl = fl; t.dg = dg;
    tbl.push_back(t);
  endtask

  task automatic pulse_ss();
    startStop = 1'b1; @(negedge clock); startStop = 1'b0;
  endtask

  // Wait (bounded) for a negedge where the wrapping DUT is RUNNING and sees a marker.
  task automatic wait_marker();
    int n = 0;
    do begin @(negedge clock); n++; end while (!(mk_w && run_w && !tr_w) && n < 200);
    chk("marker_wait", 16'(n < 200), 16'(1));
  endtask

  // Consume one second; with full set, check tick/timerReset timing and digits.
  task automatic sec_step(input logic [15:0] exp, input bit full);
    wait_marker();
    @(negedge clock);
    if (full) begin
      chk("step_tick", 16'(tk_w), 16'(1));
      chk("step_trst_hi", 16'(tr_w), 16'(1));
      chk("step_digits", dig_w(), exp);
    end
    @(negedge clock);
    if (full) begin
      chk("step_trst_lo", 16'(tr_w), 16'(0));
      chk("step_ten_hi", 16'(te_w), 16'(1));
    end
  endtask

  initial begin
    int saved;

    // flags: IDLE 01000, RUNNING 10100, RESTART+tick 11010, PAUSED 00000
    v(3'b000, 5'b01000, 16'h0000);  // idle
    v(3'b001, 5'b01000, 16'h0000);  // marker ignored in IDLE
    v(3'b100, 5'b10100, 16'h0000);  // start
    v(3'b000, 5'b10100, 16'h0000);
    v(3'b001, 5'b11010, 16'h0001);  // counted -> RESTART
    v(3'b001, 5'b10100, 16'h0001);  // stale marker ignored in RESTART
    v(3'b000, 5'b10100, 16'h0001);
    v(3'b101, 5'b11010, 16'h0002);  // stop + marker together
    v(3'b001, 5'b00000, 16'h0002);  // pending stop -> PAUSED
    v(3'b001, 5'b00000, 16'h0002);  // marker ignored in PAUSED
    v(3'b100, 5'b10100, 16'h0002);  // resume
    v(3'b001, 5'b11010, 16'h0003);
    v(3'b100, 5'b00000, 16'h0003);  // stop during RESTART
    v(3'b100, 5'b10100, 16'h0003);
    v(3'b001, 5'b11010, 16'h0004);
    v(3'b010, 5'b01000, 16'h0000);  // clear in RESTART
    v(3'b100, 5'b10100, 16'h0000);
    v(3'b111, 5'b01000, 16'h0000);  // clear beats start and marker
    v(3'b100, 5'b10100, 16'h0000);
    v(3'b011, 5'b01000, 16'h0000);  // clear beats marker, no tick
    v(3'b100, 5'b10100, 16'h0000);
    v(3'b100, 5'b00000, 16'h0000);  // stop alone
    v(3'b001, 5'b00000, 16'h0000);
    v(3'b100, 5'b10100, 16'h0000);
    v(3'b000, 5'b10100, 16'h0000);

    // Reset state
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_flags_w", 16'(fl_w()), 16'(5'b01000));
    chk("rst_digits_w", dig_w(), 16'h0000);
    chk("rst_flags_n", 16'(fl_n()), 16'(5'b01000));
    reset = 1'b1;
    @(negedge clock);
    chk("postrst_flags_w", 16'(fl_w()), 16'(5'b01000));
    chk("postrst_digits_w", dig_w(), 16'h0000);

    // Table vectors through the scoreboard queue
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      {startStop, clear, tbl_mk} = tbl[i].in;
      exp_q.push_back(tbl[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_flags_w", i), 16'(fl_w()), 16'(e.fl));
      chk($sformatf("vec%0d_digits_w", i), dig_w(), e.dg);
      chk($sformatf("vec%0d_flags_n", i), 16'(fl_n()), 16'(e.fl));
      chk($sformatf("vec%0d_digits_n", i), dig_n(), e.dg);
    end
    @(negedge clock);
    {startStop, clear, tbl_mk} = 3'b010;
    @(negedge clock);
    clear = 1'b0;
    use_tbl = 1'b0;

    // Three timed seconds with the timer model
    pulse_ss();
    for (int k = 1; k <= 3; k++) sec_step(16'(k), 1'b1);

    // Stop coinciding with a marker at 00:05, then pause/resume mid-second
    clear = 1'b1; @(negedge clock); clear = 1'b0;
    pulse_ss();
    for (int k = 1; k <= 5; k++) sec_step(16'(k), 1'b0);
    chk("at_0005", dig_w(), 16'h0005);
    wait_marker();
    startStop = 1'b1;
    @(negedge clock);
    startStop = 1'b0;
    chk("ssmk_tick", 16'(tk_w), 16'(1));
    chk("ssmk_digits", dig_w(), 16'h0006);
    @(negedge clock);
    chk("ssmk_paused", 16'(fl_w()), 16'(5'b00000));
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("paused_ten", 16'(te_w), 16'(0));
    end
    pulse_ss();
    chk("resume_run", 16'(fl_w()), 16'(5'b10100));
    repeat (3) @(negedge clock);
    pulse_ss();
    saved = tcnt_w;
    chk("midpause_flags", 16'(fl_w()), 16'(5'b00000));
    repeat (4) @(negedge clock);
    chk("midpause_hold", 16'(tcnt_w), 16'(saved));
    pulse_ss();
    sec_step(16'h0007, 1'b1);

    // Run to 12:33, then clear inside RESTART of the 12:34 second
    term = 2;
    for (int k = 8; k <= 753; k++) sec_step(16'h0000, 1'b0);
    chk("at_1233", dig_w(), 16'h1233);
    wait_marker();
    @(negedge clock);
    chk("r1234_digits", dig_w(), 16'h1234);
    chk("r1234_restart", 16'(tr_w), 16'(1));
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_flags_w", 16'(fl_w()), 16'(5'b01000));
    chk("clr_digits_w", dig_w(), 16'h0000);
    chk("clr_digits_n", dig_n(), 16'h0000);

    // Carry chain up to 59:59 and the wrap/saturate boundary
    pulse_ss();
    for (int k = 1; k <= 59; k++) sec_step(16'h0000, 1'b0);
    chk("at_0059", dig_w(), 16'h0059);
    sec_step(16'h0100, 1'b1);
    for (int k = 61; k <= 3599; k++) sec_step(16'h0000, 1'b0);
    chk("at_5959_w", dig_w(), 16'h5959);
    chk("at_5959_n", dig_n(), 16'h5959);
    wait_marker();
    @(negedge clock);
    chk("wrap_digits", dig_w(), 16'h0000);
    chk("wrap_tick", 16'(tk_w), 16'(1));
    chk("wrap_rollover", 16'(ro_w), 16'(1));
    chk("sat_digits", dig_n(), 16'h5959);
    chk("sat_flags", 16'(fl_n()), 16'(5'b00000));
    @(negedge clock);
    chk("wrap_ro_pulse", 16'(ro_w), 16'(0));
    chk("wrap_tick_pulse", 16'(tk_w), 16'(0));
    chk("sat_hold_digits", dig_n(), 16'h5959);
    chk("sat_hold_flags", 16'(fl_n()), 16'(5'b00000));

    // Asynchronous reset in the middle of a running count
    sec_step(16'h0001, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_flags_w", 16'(fl_w()), 16'(5'b01000));
    chk("midrst_digits_w", dig_w(), 16'h0000);
    chk("midrst_digits_n", dig_n(), 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("after_midrst_w", 16'(fl_w()), 16'(5'b01000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Downstream consumer of the one-second timer's `secondMarker`; also drives that timer's `reset`/`isEnabled` inputs.
- Counts elapsed seconds and minutes as BCD MM:SS digits for the display stage.
- Start/stop toggles counting; clear zeroes the count.
- Restarts the timer after every marker, because the timer saturates and holds its marker high until it is reset.

Parameters:
- WRAP_ENABLE, 1: 1 = wrap 59:59 -> 00:00 with a rollover pulse; 0 = saturate at 59:59 and stop (return to PAUSED).

Ports:
- clock  input  1  system clock, shared with the timer.
- reset  input  1  asynchronous, active-low; block is in reset while 0.
- startStop  input  1  single-cycle pulse, synchronous to clock; toggles run/pause.
- clear  input  1  single-cycle pulse; zeroes digits and timer, goes to IDLE.
- secondMarker  input  1  from timer; high once terminal count is reached.
- timerReset  output  1  to timer `reset` (active-high, synchronous in the timer).
- timerEnable  output  1  to timer `isEnabled`.
- secOnes  output  4  BCD 0-9.
- secTens  output  3  0-5.
- minOnes  output  4  BCD 0-9.
- minTens  output  3  0-5.
- running  output  1  high in RUNNING and RESTART.
- tick  output  1  one-cycle pulse on each counted second.
- rollover  output  1  one-cycle pulse on wrap 59:59 -> 00:00.

Behaviour:
- All outputs registered.
- Reset (reset=0): state=IDLE, all digits 0, timerReset=1, timerEnable=0, running=0, tick=0, rollover=0.
- States: IDLE, RUNNING, RESTART, PAUSED.
- IDLE:
  - timerReset=1, timerEnable=0.
  - startStop -> RUNNING (timerReset=0, timerEnable=1 from next cycle).
- RUNNING:
  - timerEnable=1, timerReset=0.
  - secondMarker=1 -> increment digits, tick=1 next cycle, go RESTART.
  - startStop alone -> PAUSED.
- RESTART:
  - Lasts exactly one cycle, with timerReset=1 and timerEnable=0.
  - secondMarker is ignored here; it is still high from the saturated timer.
  - Next state is RUNNING, or PAUSED if a stop is pending.
- PAUSED:
  - timerEnable=0, timerReset=0; the timer holds its partial count, so resume continues the second.
  - startStop -> RUNNING.
- Any state, clear=1 -> IDLE, digits 0, timerReset=1. Clear has priority over startStop and secondMarker.
- Tick timing:
  - Marker sampled at edge N -> digits/tick update at edge N+1 -> timer cleared at edge N+2.
  - Each counted second spans the timer terminal count plus 2 clock cycles.
- Increment carry chain, evaluated in one cycle:
  - secOnes 9 -> 0 with carry to secTens.
  - secTens 5 -> 0 with carry to minOnes.
  - minOnes 9 -> 0 with carry to minTens.
  - minTens 5 -> 0 at 59:59: rollover=1 if WRAP_ENABLE; otherwise hold 59:59, no tick, next state PAUSED.
- startStop and secondMarker in the same RUNNING cycle: the second is counted, RESTART executes, then PAUSED.
- startStop during RESTART: latched as a pending stop; applied on exit.
- secondMarker in IDLE/PAUSED: ignored.
- Reset asserted mid-operation: immediate return to reset values, regardless of state.

Decomposition:
- Shared package holds:
  - the state enum `sw_state_t`;
  - localparams SEC_TENS_MAX=5, MIN_TENS_MAX=5, BCD_MAX=9.
- One sub-module: `bcd_digit_counter` (param MAX), with inputs inc and clr and outputs value and carry. Instantiated 4x in a chain.

Test Plan:
- Hold reset=0 then release -> digits 00:00, timerReset=1, timerEnable=0, running=0.
- startStop, then 3 marker events (timer model terminal=10) -> 00:03, three tick pulses, timerReset high exactly 1 cycle after each marker.
- Preload via 59 markers at 00:00 -> 00:59; one more marker -> 01:00, secTens carry into minOnes.
- At 59:59 with WRAP_ENABLE=1, one marker -> 00:00, rollover=1 for one cycle; with WRAP_ENABLE=0 -> stays 59:59, state PAUSED, timerEnable=0.
- startStop and secondMarker in the same cycle at 00:05 -> 00:06, then PAUSED; resume after 4 idle cycles -> timer resumes from held count, next tick yields 00:07.
- clear during RESTART at 12:34 -> 00:00, IDLE, timerReset=1, no tick; reset pulse mid-run -> same reset values.
